// File: rtl/reg16_byte_read_pkg.sv
// ============================================================================
// Module  : reg16_byte_read_pkg
// Purpose : Shared types and widths for the 16-bit byte-serialising reader.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package reg16_byte_read_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  localparam logic LO_BYTE = 1'b0;
  localparam logic HI_BYTE = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/reg16_byte_read_byte_select_mux.sv
// ============================================================================
// Module  : byte_select_mux
// Purpose : Picks one byte of the held word by index; zero when not valid.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module byte_select_mux
  import reg16_byte_read_pkg::*;
(
  input  logic [WORD_W-1:0] i_hold,
  input  logic              i_sel,
  input  logic              i_valid,
  output logic [BYTE_W-1:0] o_byte
);

  always_comb begin
    o_byte = '0;
    if (i_valid) begin
      o_byte = (i_sel == HI_BYTE) ? i_hold[WORD_W-1:BYTE_W] : i_hold[BYTE_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg16_byte_read.sv
// ============================================================================
// Module  : reg16_byte_read
// Purpose : Accepts a 16-bit word and emits it as two handshaked bytes.
//           REG16_BYTE_READ_HIGH_FIRST_EN selects high-byte-first order.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module reg16_byte_read
  import reg16_byte_read_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              loadValid,
  output logic              loadReady,
  input  logic [WORD_W-1:0] dataIn,
  input  logic              flush,
  output logic              byteValid,
  input  logic              byteReady,
  output logic [BYTE_W-1:0] dataOut,
  output logic              byteSel,
  output logic              lastByte
);

`ifdef REG16_BYTE_READ_HIGH_FIRST_EN
  localparam logic c_FIRST_IDX  = HI_BYTE;
  localparam logic c_SECOND_IDX = LO_BYTE;
`else
  localparam logic c_FIRST_IDX  = LO_BYTE;
  localparam logic c_SECOND_IDX = HI_BYTE;
`endif

  state_t            r_state;
  state_t            w_next;
  logic [WORD_W-1:0] r_hold;
  logic              w_load;
  logic              w_idx;

  // Load only from IDLE and never in a flush cycle.
  assign w_load = (r_state == IDLE) && loadValid && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_hold <= dataIn;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (loadValid) w_next = FIRST;
        FIRST:   if (byteReady) w_next = SECOND;
        SECOND:  if (byteReady) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // All outputs decode from state and hold only.
  assign loadReady = (r_state == IDLE);
  assign byteValid = (r_state == FIRST) || (r_state == SECOND);
  assign lastByte  = (r_state == SECOND);
  assign w_idx     = (r_state == SECOND) ? c_SECOND_IDX : c_FIRST_IDX;
  assign byteSel   = byteValid ? w_idx : LO_BYTE;

  byte_select_mux u_mux (
    .i_hold  (r_hold),
    .i_sel   (w_idx),
    .i_valid (byteValid),
    .o_byte  (dataOut)
  );

endmodule

`default_nettype wire

// File: tb/tb_reg16_byte_read.sv
// ============================================================================
// Module  : tb_reg16_byte_read
// Purpose : Self-checking bench for reg16_byte_read against a byte-queue model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_reg16_byte_read;

  logic        clk = 1'b0;
  logic        reset;
  logic        loadValid;
  logic        loadReady;
  logic [15:0] dataIn;
  logic        flush;
  logic        byteValid;
  logic        byteReady;
  logic [7:0]  dataOut;
  logic        byteSel;
  logic        lastByte;

  int n_checks = 0;
  int n_errors = 0;

  // Model: bytes still owed to the consumer, each tagged {byteSel, byte}.
  logic [8:0] q[$];

`ifdef REG16_BYTE_READ_HIGH_FIRST_EN
  localparam bit HF = 1'b1;
`else
  localparam bit HF = 1'b0;
`endif

  always #5 clk = ~clk;

  reg16_byte_read dut (
    .clk       (clk),
    .reset     (reset),
    .loadValid (loadValid),
    .loadReady (loadReady),
    .dataIn    (dataIn),
    .flush     (flush),
    .byteValid (byteValid),
    .byteReady (byteReady),
    .dataOut   (dataOut),
    .byteSel   (byteSel),
    .lastByte  (lastByte)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    if (q.size() == 0) begin
      chk({tag, ".loadReady"}, {15'd0, loadReady}, 16'd1);
      chk({tag, ".byteValid"}, {15'd0, byteValid}, 16'd0);
      chk({tag, ".dataOut"},   {8'd0, dataOut},    16'd0);
      chk({tag, ".byteSel"},   {15'd0, byteSel},   16'd0);
      chk({tag, ".lastByte"},  {15'd0, lastByte},  16'd0);
    end else begin
      chk({tag, ".loadReady"}, {15'd0, loadReady}, 16'd0);
      chk({tag, ".byteValid"}, {15'd0, byteValid}, 16'd1);
      chk({tag, ".dataOut"},   {8'd0, dataOut},    {8'd0, q[0][7:0]});
      chk({tag, ".byteSel"},   {15'd0, byteSel},   {15'd0, q[0][8]});
      chk({tag, ".lastByte"},  {15'd0, lastByte},  {15'd0, (q.size() == 1)});
    end
  endtask

  // Check current outputs, clock once with the driven inputs, advance the model.
  task automatic step(input string tag, input logic lv, input logic [15:0] din,
                      input logic br, input logic fl, input logic rs);
    loadValid = lv;
    dataIn    = din;
    byteReady = br;
    flush     = fl;
    reset     = rs;
    check_outputs(tag);
    @(posedge clk);
    if (rs || fl) begin
      q.delete();
    end else if (q.size() == 0) begin
      if (lv) begin
        if (HF) begin
          q.push_back({1'b1, din[15:8]});
          q.push_back({1'b0, din[7:0]});
        end else begin
          q.push_back({1'b0, din[7:0]});
          q.push_back({1'b1, din[15:8]});
        end
      end
    end else if (br) begin
      void'(q.pop_front());
    end
    #1;
  endtask

  initial begin
    loadValid = 1'b0;
    dataIn    = 16'h0000;
    byteReady = 1'b0;
    flush     = 1'b0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();

    // Reset state, then 16'hBEEF with byteReady high.
    step("rst", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step("beef_ld", 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    chk("beef_b0", {8'd0, dataOut}, HF ? 16'h00BE : 16'h00EF);
    step("beef_b0s", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("beef_b1", {8'd0, dataOut}, HF ? 16'h00EF : 16'h00BE);
    chk("beef_last", {15'd0, lastByte}, 16'd1);
    step("beef_b1s", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("beef_ready", {15'd0, loadReady}, 16'd1);

    // Backpressure on the first byte.
    step("bp_ld", 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("bp_hold", 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      chk("bp_stable", {8'd0, dataOut}, HF ? 16'h0012 : 16'h0034);
    end
    step("bp_rel0", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step("bp_rel1", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Load while busy, with dataIn churning during the transfer.
    step("busy_ld", 1'b1, 16'h5678, 1'b1, 1'b0, 1'b0);
    step("busy_b0", 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
    step("busy_b0r", 1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0);
    step("busy_b1", 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
    chk("busy_no_cap", {8'd0, dataOut}, HF ? 16'h0078 : 16'h0056);
    step("busy_b1r", 1'b0, 16'hAAAA, 1'b1, 1'b0, 1'b0);
    step("busy_idle", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Flush in FIRST together with byte and load handshakes.
    step("fl_ld", 1'b1, 16'h9ABC, 1'b0, 1'b0, 1'b0);
    step("fl_hit", 1'b1, 16'h4321, 1'b1, 1'b1, 1'b0);
    chk("fl_idle", {15'd0, byteValid}, 16'd0);
    step("fl_after", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Synchronous reset mid-SECOND, then 16'h00FF.
    step("rs_ld", 1'b1, 16'hCAFE, 1'b1, 1'b0, 1'b0);
    step("rs_b0", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step("rs_hit", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    step("rs_ff_ld", 1'b1, 16'h00FF, 1'b1, 1'b0, 1'b0);
    chk("rs_ff_b0", {8'd0, dataOut}, HF ? 16'h0000 : 16'h00FF);
    step("rs_ff_b0s", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step("rs_ff_b1s", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Back-to-back loads with loadValid held: one idle cycle between words.
    step("b2b_ld0", 1'b1, 16'h0102, 1'b1, 1'b0, 1'b0);
    step("b2b_a0", 1'b1, 16'h0304, 1'b1, 1'b0, 1'b0);
    step("b2b_a1", 1'b1, 16'h0304, 1'b1, 1'b0, 1'b0);
    chk("b2b_gap", {15'd0, loadReady}, 16'd1);
    step("b2b_ld1", 1'b1, 16'h0304, 1'b1, 1'b0, 1'b0);
    step("b2b_b0", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step("b2b_b1", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           ($urandom_range(0, 1) == 1),
           16'($urandom),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 39) == 0));
    end
    step("end", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
